// File: rtl/mem_responder.sv
// mem_responder: single-port word memory behind a req/ready handshake
// that inserts LATENCY wait cycles before each one-cycle response.
//
// Ports:
//   clk    - clock; all state changes on the rising edge
//   rst    - asynchronous active-low reset
//   req    - request, sampled only while idle
//   we     - 1 = write, 0 = read (qualified by req)
//   adr    - byte address; word index is adr[log2(DEPTH)+1:2]
//   wd     - write data
//   rd     - registered read data, held until the next completed read
//   ready  - one-cycle response strobe
//   err    - misaligned access flag, valid while ready = 1
//
// Optional feature: define MEM_RESPONDER_ALIGN_CHECK_EN to flag
// accesses with adr[1:0] != 0 (write suppressed, rd unchanged).
// Without it, adr[1:0] is ignored and err stays 0.

module mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] adr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        ready,
    output logic        err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          we_q, we_d;
    logic [31:0]   wd_q, wd_d;
    logic          mis_q, mis_d;
    logic [31:0]   rd_q, rd_d;
    logic          ready_q, ready_d;
    logic          err_q, err_d;
    logic          mem_wr;
    logic          mis_in;
    logic          unused_adr;

    logic [31:0]   mem [DEPTH];

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    assign mis_in     = |adr[1:0];
    assign unused_adr = ^adr[31:AW+2];
`else
    assign mis_in     = 1'b0;
    assign unused_adr = ^{adr[31:AW+2], adr[1:0]};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        we_d    = we_q;
        wd_d    = wd_q;
        mis_d   = mis_q;
        rd_d    = rd_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        mem_wr  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    idx_d   = adr[AW+1:2];
                    we_d    = we;
                    wd_d    = wd;
                    mis_d   = mis_in;
                    cnt_d   = 4'(LATENCY);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    // This edge enters RESP: commit the access
                    // and raise the strobe for exactly one cycle.
                    state_d = RESP;
                    ready_d = 1'b1;
                    err_d   = mis_q;
                    if (!mis_q) begin
                        if (we_q) begin
                            mem_wr = 1'b1;
                        end else begin
                            rd_d = mem[idx_q];
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            wd_q    <= 32'h0;
            mis_q   <= 1'b0;
            rd_q    <= 32'h0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            wd_q    <= wd_d;
            mis_q   <= mis_d;
            rd_q    <= rd_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    // Storage is deliberately not reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[idx_q] <= wd_q;
        end
    end

    assign rd    = rd_q;
    assign ready = ready_q;
    assign err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed and random transactions on two instances
// (LATENCY 2 and LATENCY 0) checked against a word-array model.

module tb_mem_responder;

    localparam int DEPTH = 1024;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        we  = 1'b0;
    logic [31:0] adr = 32'h0;
    logic [31:0] wd  = 32'h0;
    int          sel = 0;

    logic        req0, req1;
    logic [31:0] rd0, rd1;
    logic        rdy0, rdy1, err0, err1;

    assign req0 = req && (sel == 0);
    assign req1 = req && (sel == 1);

    mem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u0 (
        .clk(clk), .rst(rst), .req(req0), .we(we), .adr(adr),
        .wd(wd), .rd(rd0), .ready(rdy0), .err(err0)
    );

    mem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u1 (
        .clk(clk), .rst(rst), .req(req1), .we(we), .adr(adr),
        .wd(wd), .rd(rd1), .ready(rdy1), .err(err1)
    );

    always #5 clk = ~clk;

    logic [31:0] mdl [int];
    logic [31:0] rdm [2];
    bit          rdk [2];
    int          checks   = 0;
    int          failures = 0;

    function automatic logic [31:0] rd_o();
        return (sel == 1) ? rd1 : rd0;
    endfunction

    function automatic logic rdy_o();
        return (sel == 1) ? rdy1 : rdy0;
    endfunction

    function automatic logic err_o();
        return (sel == 1) ? err1 : err0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] o,
                       input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic scramble();
        req = 1'($urandom_range(0, 1));
        we  = 1'($urandom_range(0, 1));
        adr = $urandom;
        wd  = $urandom;
    endtask

    // Drive one transaction starting in IDLE, mid-cycle; ends in IDLE.
    task automatic txn(input bit w, input logic [31:0] a,
                       input logic [31:0] d);
        int lat;
        int key;
        bit mis;
        lat = (sel == 1) ? 0 : 2;
        key = sel * DEPTH + int'((a >> 2) % DEPTH);
        mis = ALIGN && (a[1:0] != 2'b00);
        req = 1'b1;
        we  = w;
        adr = a;
        wd  = d;
        @(posedge clk);
        #1;
        for (int k = 1; k <= lat + 1; k++) begin
            scramble();
            @(posedge clk);
            #1;
            chk("ready_wait", 32'(rdy_o()), 32'(k == lat + 1));
        end
        if (!mis) begin
            if (w) begin
                mdl[key] = d;
            end else if (mdl.exists(key)) begin
                rdm[sel] = mdl[key];
                rdk[sel] = 1'b1;
            end else begin
                rdk[sel] = 1'b0;
            end
        end
        chk("err", 32'(err_o()), 32'(mis));
        if (rdk[sel]) begin
            chk("rd", rd_o(), rdm[sel]);
        end
        scramble();
        @(posedge clk);
        #1;
        req = 1'b0;
        chk("ready_drop", 32'(rdy_o()), 32'h0);
    endtask

    initial begin
        #12;
        chk("rst_ready0", 32'(rdy0), 32'h0);
        chk("rst_ready1", 32'(rdy1), 32'h0);
        chk("rst_err0", 32'(err0), 32'h0);
        chk("rst_rd0", rd0, 32'h0);
        chk("rst_rd1", rd1, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        rdm[0] = 32'h0;
        rdm[1] = 32'h0;
        rdk[0] = 1'b1;
        rdk[1] = 1'b1;

        sel = 0;
        txn(1'b1, 32'h10, 32'hDEADBEEF);
        txn(1'b0, 32'h10, 32'h0);
        chk("wr_rd_10", rd0, 32'hDEADBEEF);

        txn(1'b1, 32'h0000_1004, 32'h5A5A5A5A);
        txn(1'b0, 32'h4, 32'h0);
        chk("wrap", rd0, 32'h5A5A5A5A);

        txn(1'b1, 32'h20, 32'hCAFEF00D);
        req = 1'b1;
        we  = 1'b1;
        adr = 32'h20;
        wd  = 32'h1234;
        @(posedge clk);
        #1;
        req = 1'b0;
        rst = 1'b0;
        #1;
        chk("abort_ready", 32'(rdy0), 32'h0);
        chk("abort_rd", rd0, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        rdm[0] = 32'h0;
        rdm[1] = 32'h0;
        rdk[0] = 1'b1;
        rdk[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk("abort_quiet", 32'(rdy0), 32'h0);
        end
        txn(1'b0, 32'h20, 32'h0);
        chk("abort_keep", rd0, 32'hCAFEF00D);

        txn(1'b1, 32'h22, 32'hA5A50022);
        txn(1'b0, 32'h20, 32'h0);
        chk("align_rd", rd0, ALIGN ? 32'hCAFEF00D : 32'hA5A50022);

        sel = 1;
        txn(1'b1, 32'h40, 32'h00000077);
        req = 1'b1;
        we  = 1'b0;
        adr = 32'h40;
        @(posedge clk);
        #1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            chk("held_ready", 32'(rdy1), 32'(k % 3 == 1));
            if (k % 3 == 1) begin
                chk("held_rd", rd1, 32'h00000077);
            end
        end
        req = 1'b0;
        @(posedge clk);
        #1;
        chk("held_end", 32'(rdy1), 32'h0);
        rdm[1] = 32'h00000077;
        rdk[1] = 1'b1;

        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            logic [1:0]  lo;
            sel = $urandom_range(0, 1);
            lo  = ($urandom_range(0, 3) == 0) ?
                  2'($urandom_range(1, 3)) : 2'b00;
            a = ($urandom & 32'hFFFFF000) |
                (32'($urandom_range(0, 15)) << 2) | 32'(lo);
            txn(1'($urandom_range(0, 1)), a, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
